dbb_ext_loader: RTL
===================

Name: dbb_ext_loader

Overview:
- AXI4 write/read master that drives the secondary ext2dbb port of the DBBIF dual-port DRAM model.
- The testbench or host side issues simple commands: write N 64-bit words from a stream to DRAM, or read N words from DRAM into a stream.
- The block splits each command into INCR bursts, sequences the AW/W/B or AR/R handshakes, and pulses done when the command completes.
- Preloads weights and feature data before NVDLA runs, and drains results afterwards.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 64, data beat width; fixed 64 (8 bytes per beat)
- MAX_BURST, 16, maximum beats per AXI burst (1..256)
- AXI_ID, 8'h01, constant awid/arid value

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=write DRAM, 0=read DRAM
- cmd_addr  in  ADDR_WIDTH  start byte address; bits[2:0] ignored and treated as 0
- cmd_beats  in  16  number of 64-bit beats in the command
- wdat_valid  in  1  write-data stream valid
- wdat_ready  out  1  write-data stream ready
- wdat_data  in  DATA_WIDTH  write-data word
- rdat_valid  out  1  read-data stream valid
- rdat_ready  in  1  read-data stream ready
- rdat_data  out  DATA_WIDTH  read-data word
- rdat_last  out  1  final beat of the read command
- busy  out  1  high from command accept until done
- done  out  1  one-cycle pulse when the command completes
- m_awvalid/m_awready/m_awlen[7:0]/m_awsize[2:0]/m_awburst[1:0]/m_awaddr[ADDR_WIDTH]/m_awid[7:0]  AXI write address; connects to ext2dbb_aw*
- m_wvalid/m_wready/m_wdata[DATA_WIDTH]/m_wlast/m_wstrb[DATA_WIDTH/8]  AXI write data
- m_bvalid/m_bready/m_bid[7:0]  AXI write response
- m_arvalid/m_arready/m_arlen[7:0]/m_arsize[2:0]/m_arburst[1:0]/m_araddr[ADDR_WIDTH]/m_arid[7:0]  AXI read address
- m_rvalid/m_rready/m_rlast/m_rdata[DATA_WIDTH]/m_rid[7:0]  AXI read data

Behaviour:
- Reset (async assert, sync release) values:
  - All valids, ready outputs, busy, done and rdat_last are 0.
  - FSM is in IDLE; counters are 0.
- Constant outputs:
  - awsize = arsize = 3'd3; awburst = arburst = 2'b01 (INCR).
  - wstrb = all ones; awid = arid = AXI_ID.
- FSM states: IDLE, CALC, AW, W, B, AR, R, DONE.
- IDLE:
  - cmd_ready = 1.
  - On accept: latch addr (low 3 bits zeroed), remaining = cmd_beats, dir = cmd_write.
  - If cmd_beats == 0, go to DONE with no AXI traffic; otherwise go to CALC.
- CALC (1 cycle): blen = min(remaining, MAX_BURST, (4096 - addr[11:0]) >> 3). Bursts never cross a 4 KB boundary. Next state is AW if writing, AR if reading.
- AW: awvalid = 1, awaddr = addr, awlen = blen - 1. awvalid is held with all fields stable until awready. On handshake go to W with beat counter = 0.
- W:
  - Combinational passthrough: wvalid = wdat_valid, wdat_ready = m_wready, wdata = wdat_data.
  - wlast = (beat == blen - 1).
  - No W beat is driven before its AW handshake.
  - Each handshake increments beat. After the handshake with wlast, go to B.
- B: bready = 1; m_bid is ignored. On bvalid:
  - addr += blen * 8; remaining -= blen.
  - Go to DONE if remaining == 0, else to CALC.
- AR: same rules as AW, using the ar* channel. On handshake go to R.
- R:
  - Combinational passthrough: rdat_valid = m_rvalid, m_rready = rdat_ready, rdat_data = m_rdata.
  - rdat_last = m_rlast & (remaining == blen).
  - On the handshake with m_rlast: update addr/remaining as in B, then go to DONE or CALC.
  - m_rid is ignored.
- DONE: done = 1 for exactly one cycle, then return to IDLE. busy = (state != IDLE).
- Outside W/R, wdat_ready, rdat_valid and m_rready are 0.
- Arithmetic:
  - addr is ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH.
  - remaining is 16 bits; blen is 9 bits (max 256).
- Back-pressure: any number of stall cycles on any channel is tolerated. Data beats are never dropped or duplicated.
- Only one command is in flight at a time; cmd_valid is ignored while busy.
- Asserting rst_n low mid-burst immediately drops all valids and returns to IDLE. No partial-burst completion is owed.

Test Plan:
- Write cmd addr=0x100, beats=4, data 0x11..0x44 -> one AW (awaddr=0x100, awlen=3), 4 W beats with wlast on the 4th, then B, then a single done pulse. Read cmd addr=0x100, beats=4 -> rdat 0x11..0x44 with rdat_last on beat 4.
- Write beats=40 with MAX_BURST=16 at addr=0 -> three bursts: awaddr 0x000/0x080/0x100 with awlen 15/15/7; readback matches.
- 4 KB crossing: write addr=0xFF0, beats=6 -> bursts awaddr=0xFF0 awlen=1, then awaddr=0x1000 awlen=3.
- cmd_beats=0 -> no AXI valid ever asserted; done pulses 2 cycles after accept; busy is high only for the intervening cycle.
- Random back-pressure: random stalls on wdat_valid, rdat_ready and the DRAM readies over a 64-beat write+read -> data identical, AW/AR fields stable while valid is held, exactly one done per command.
- Reset asserted during W beat 2 of 8 -> all valids 0 immediately, busy=0. A new write cmd after reset completes normally.

Source files
------------

// File: rtl/dbb_ext_loader.sv
// dbb_ext_loader
//   AXI4 master for the secondary (ext2dbb) port of the DBBIF DRAM model.
//   A host command moves N 64-bit words between a simple valid/ready stream
//   and DRAM. Each command is split into INCR bursts of at most MAX_BURST
//   beats that never cross a 4 KB page. done pulses once per command.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/beats   command request (write=1: stream -> DRAM)
//   wdat_valid/ready/data              write-data stream into the block
//   rdat_valid/ready/data/last         read-data stream out of the block
//   busy, done                         command in progress / completion pulse
//   m_aw*, m_w*, m_b*                  AXI write address, data, response
//   m_ar*, m_r*                        AXI read address, data
module dbb_ext_loader #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 64,
  parameter int          MAX_BURST  = 16,
  parameter logic [7:0]  AXI_ID     = 8'h01
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [15:0]             cmd_beats,
  input  logic                    wdat_valid,
  output logic                    wdat_ready,
  input  logic [DATA_WIDTH-1:0]   wdat_data,
  output logic                    rdat_valid,
  input  logic                    rdat_ready,
  output logic [DATA_WIDTH-1:0]   rdat_data,
  output logic                    rdat_last,
  output logic                    busy,
  output logic                    done,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awid,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic                    m_wlast,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [7:0]              m_bid,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arid,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic                    m_rlast,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [7:0]              m_rid
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [15:0]             remaining;
  logic [8:0]              blen;
  logic [8:0]              beat;
  logic                    dir;
  logic                    alive;   // keeps cmd_ready low while reset is held
  logic                    done_r;

  // Burst length candidate: limited by what is left, by MAX_BURST and by the
  // room left in the current 4 KB page (addr is always 8-byte aligned).
  logic [9:0]  page_room;
  logic [15:0] lim;
  logic [8:0]  blen_calc;

  always_comb begin
    page_room = 10'd512 - {1'b0, addr[11:3]};
    lim       = remaining;
    if (lim > 16'(MAX_BURST)) lim = 16'(MAX_BURST);
    if (lim > {6'd0, page_room}) lim = {6'd0, page_room};
    blen_calc = lim[8:0];
  end

  logic [8:0]            blen_m1;
  logic                  w_last_beat;
  logic                  w_hs;
  logic                  r_hs;
  logic                  final_burst;
  logic [ADDR_WIDTH-1:0] addr_step;

  assign blen_m1     = blen - 9'd1;
  assign w_last_beat = (beat == blen_m1);
  assign w_hs        = (state == S_W) && wdat_valid && m_wready;
  assign r_hs        = (state == S_R) && m_rvalid && rdat_ready;
  assign final_burst = (remaining == {7'd0, blen});
  assign addr_step   = {{(ADDR_WIDTH-12){1'b0}}, blen, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      blen      <= '0;
      beat      <= '0;
      dir       <= 1'b0;
      alive     <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      alive  <= 1'b1;
      done_r <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr      <= {cmd_addr[ADDR_WIDTH-1:3], 3'b000};
            remaining <= cmd_beats;
            dir       <= cmd_write;
            state     <= (cmd_beats == 16'd0) ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          blen  <= blen_calc;
          state <= dir ? S_AW : S_AR;
        end
        S_AW: begin
          if (m_awready) begin
            beat  <= '0;
            state <= S_W;
          end
        end
        S_W: begin
          if (w_hs) begin
            beat <= beat + 9'd1;
            if (w_last_beat) state <= S_B;
          end
        end
        S_B: begin
          if (m_bvalid) begin
            addr      <= addr + addr_step;
            remaining <= remaining - {7'd0, blen};
            state     <= final_burst ? S_DONE : S_CALC;
          end
        end
        S_AR: begin
          if (m_arready) state <= S_R;
        end
        S_R: begin
          if (r_hs && m_rlast) begin
            addr      <= addr + addr_step;
            remaining <= remaining - {7'd0, blen};
            state     <= final_burst ? S_DONE : S_CALC;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = alive && (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = done_r;

  assign m_awvalid = (state == S_AW);
  assign m_awaddr  = addr;
  assign m_awlen   = blen_m1[7:0];
  assign m_awsize  = 3'd3;
  assign m_awburst = 2'b01;
  assign m_awid    = AXI_ID;

  // W and R are straight passthroughs gated by the FSM state.
  assign m_wvalid   = (state == S_W) && wdat_valid;
  assign wdat_ready = (state == S_W) && m_wready;
  assign m_wdata    = wdat_data;
  assign m_wlast    = (state == S_W) && w_last_beat;
  assign m_wstrb    = '1;
  assign m_bready   = (state == S_B);

  assign m_arvalid = (state == S_AR);
  assign m_araddr  = addr;
  assign m_arlen   = blen_m1[7:0];
  assign m_arsize  = 3'd3;
  assign m_arburst = 2'b01;
  assign m_arid    = AXI_ID;

  assign rdat_valid = (state == S_R) && m_rvalid;
  assign m_rready   = (state == S_R) && rdat_ready;
  assign rdat_data  = m_rdata;
  assign rdat_last  = (state == S_R) && m_rlast && final_burst;

  // Response IDs and the sub-word address bits carry no information here.
  logic unused_ok;
  assign unused_ok = ^{m_bid, m_rid, cmd_addr[2:0], lim[15:9], blen_m1[8]};

endmodule
